// File: rtl/conbus_slvsel_pkg.sv
// Shared conbus definitions: slave count, select-field position, FSM encodings
// and the one-hot slave-select helper.
package conbus_slvsel_pkg;

  localparam int NSLV   = 5;
  localparam int SEL_HI = 31;
  localparam int SEL_LO = 29;
  localparam int SEL_W  = SEL_HI - SEL_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  // Select values 5..7 decode to no slave and yield an all-zero vector.
  function automatic logic [NSLV-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NSLV-1:0] oh;
    oh = '0;
    for (int k = 0; k < NSLV; k++) begin
      oh[k] = (sel == SEL_W'(k));
    end
    return oh;
  endfunction

  function automatic logic sel_mapped(input logic [SEL_W-1:0] sel);
    return (sel < SEL_W'(NSLV));
  endfunction

endpackage

// File: rtl/conbus_wdt.sv
// Bus watchdog counter: cleared on load, counts stalled cycles, saturates,
// and flags the terminal count TIMEOUT-1.
module conbus_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Stall counter; holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Terminal count decode.
  always_comb begin
    o_tc = (r_cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/conbus_slvsel.sv
// conbus slave-side address decoder with watchdog: routes the granted master
// cycle to one of five slaves and errors unmapped or unresponsive accesses.
module conbus_slvsel
  import conbus_slvsel_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          m_adr,
  input  logic                 m_cyc,
  input  logic                 m_stb,
  output logic                 m_ack,
  output logic                 m_err,
  output logic [31:0]          m_dat_r,
  output logic [NSLV-1:0]      s_cyc,
  output logic [NSLV-1:0]      s_stb,
  input  logic [NSLV-1:0]      s_ack,
  input  logic [NSLV*32-1:0]   s_dat_r,
  output logic                 err_flag,
  output logic [31:0]          err_adr,
  input  logic                 err_clr
);

  state_e            r_state;
  state_e            w_next;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_adr_sel;
  logic [NSLV-1:0]   w_sel_oh;
  logic [31:0]       w_sel_dat;
  logic              w_wdt_load;
  logic              w_wdt_inc;
  logic              w_wdt_tc;
  logic              w_ack;
  logic              w_err;
  logic [31:0]       w_dat;
  logic [NSLV-1:0]   w_cyc;
  logic [NSLV-1:0]   w_stb;

  assign w_adr_sel = m_adr[SEL_HI:SEL_LO];
  assign w_sel_oh  = sel_onehot(r_sel);

  conbus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst),
    .i_load  (w_wdt_load),
    .i_inc   (w_wdt_inc),
    .o_tc    (w_wdt_tc)
  );

  // Read-data mux driven by the latched slave select.
  always_comb begin
    w_sel_dat = 32'h0000_0000;
    case (r_sel)
      3'd0:    w_sel_dat = s_dat_r[31:0];
      3'd1:    w_sel_dat = s_dat_r[63:32];
      3'd2:    w_sel_dat = s_dat_r[95:64];
      3'd3:    w_sel_dat = s_dat_r[127:96];
      3'd4:    w_sel_dat = s_dat_r[159:128];
      default: w_sel_dat = 32'h0000_0000;
    endcase
  end

  // Next-state and bus-side outputs; the ack path outranks the watchdog.
  always_comb begin
    w_next     = r_state;
    w_wdt_load = 1'b0;
    w_wdt_inc  = 1'b0;
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_dat      = 32'h0000_0000;
    w_cyc      = '0;
    w_stb      = '0;
    case (r_state)
      ST_IDLE: begin
        if (m_cyc && m_stb) begin
          if (sel_mapped(w_adr_sel)) begin
            w_next     = ST_ACTIVE;
            w_wdt_load = 1'b1;
          end else begin
            w_next = ST_ERR;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        w_cyc = w_sel_oh & {NSLV{m_cyc}};
        w_stb = w_sel_oh & {NSLV{m_stb}};
        w_ack = (|(s_ack & w_sel_oh)) & m_stb;
        w_dat = w_sel_dat;
        if (!m_cyc) begin
          w_next = ST_IDLE;
        end else if (w_ack) begin
          w_next = ST_IDLE;
        end else begin
          w_wdt_inc = 1'b1;
          if (w_wdt_tc) begin
            w_next = ST_ERR;
          end else begin
            w_next = ST_ACTIVE;
          end
        end
      end
      ST_ERR: begin
        w_err  = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, slave select and sticky error capture; a new error beats err_clr.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      err_flag <= 1'b0;
      err_adr  <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      if (w_wdt_load) begin
        r_sel <= w_adr_sel;
      end
      if (w_next == ST_ERR) begin
        err_flag <= 1'b1;
        err_adr  <= m_adr;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end

  // Reset silences the bus in the same cycle it is asserted.
  always_comb begin
    if (sys_rst) begin
      m_ack   = w_ack;
      m_err   = w_err;
      m_dat_r = w_dat;
      s_cyc   = w_cyc;
      s_stb   = w_stb;
    end else begin
      m_ack   = 1'b0;
      m_err   = 1'b0;
      m_dat_r = 32'h0000_0000;
      s_cyc   = '0;
      s_stb   = '0;
    end
  end

endmodule

// File: tb/tb_conbus_slvsel.sv
// Cycle-vector bench for conbus_slvsel with TIMEOUT=8: each row is one clock
// of master/slave stimulus plus the hand-derived bus outputs for that cycle.
module tb_conbus_slvsel;

  localparam int TMO = 8;

  localparam logic [31:0] D0 = 32'h0F0F_0F0F;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] D4 = 32'h4444_4444;

  localparam logic [31:0] A0  = 32'h1FFF_FFFF;
  localparam logic [31:0] A1  = 32'h2000_0004;
  localparam logic [31:0] A1B = 32'h3FFF_FFFC;
  localparam logic [31:0] A2  = 32'h4000_0010;
  localparam logic [31:0] A3  = 32'h6000_0000;
  localparam logic [31:0] A3B = 32'h6000_0040;
  localparam logic [31:0] A4  = 32'h8000_0100;
  localparam logic [31:0] A5  = 32'hA000_0000;
  localparam logic [31:0] AU  = 32'hE000_0000;
  localparam logic [31:0] Z   = 32'h0000_0000;

  typedef struct {
    logic        rst;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [4:0]  ack;
    logic        clr;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
    logic [4:0]  e_scyc;
    logic [4:0]  e_sstb;
    logic        e_flag;
    logic [31:0] e_eadr;
  } vec_t;

  logic          sys_clk;
  logic          sys_rst;
  logic [31:0]   m_adr;
  logic          m_cyc;
  logic          m_stb;
  logic          m_ack;
  logic          m_err;
  logic [31:0]   m_dat_r;
  logic [4:0]    s_cyc;
  logic [4:0]    s_stb;
  logic [4:0]    s_ack;
  logic [159:0]  s_dat_r;
  logic          err_flag;
  logic [31:0]   err_adr;
  logic          err_clr;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks;
  int   n_errors;

  conbus_slvsel #(.TIMEOUT(TMO)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .m_adr    (m_adr),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_dat_r  (m_dat_r),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_ack    (s_ack),
    .s_dat_r  (s_dat_r),
    .err_flag (err_flag),
    .err_adr  (err_adr),
    .err_clr  (err_clr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic add(input logic rst, input logic cyc, input logic stb, input logic [31:0] adr,
                     input logic [4:0] ack, input logic clr, input logic e_ack, input logic e_err,
                     input logic [31:0] e_dat, input logic [4:0] e_scyc, input logic [4:0] e_sstb,
                     input logic e_flag, input logic [31:0] e_eadr);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.adr = adr; v.ack = ack; v.clr = clr;
    v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat; v.e_scyc = e_scyc;
    v.e_sstb = e_sstb; v.e_flag = e_flag; v.e_eadr = e_eadr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    n_checks = 0;
    n_errors = 0;
    s_dat_r  = {D4, D3, D2, D1, D0};
    sys_rst  = 1'b0;
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    m_adr    = Z;
    s_ack    = 5'b00000;
    err_clr  = 1'b0;

    // Reset state, then stb without cyc must not decode.
    add(1'b1, 1'b0, 1'b0, Z,   5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b0, 1'b1, A2,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b0, 1'b0, Z,   5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);

    // Slave 2 read with three wait cycles.
    add(1'b1, 1'b1, 1'b1, A2, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    for (int i = 0; i < 3; i++)
      add(1'b1, 1'b1, 1'b1, A2, 5'b00000, 1'b0, 1'b0, 1'b0, D2, 5'b00100, 5'b00100, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A2, 5'b00100, 1'b0, 1'b1, 1'b0, D2, 5'b00100, 5'b00100, 1'b0, Z);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);

    // Unmapped address, then err_clr.
    add(1'b1, 1'b1, 1'b1, AU, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b1, Z, 5'b00000, 5'b00000, 1'b1, AU);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b1, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, AU);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, AU);

    // Slave 4 never acks: stb for TMO cycles, error in cycle TMO+1.
    add(1'b1, 1'b1, 1'b1, A4, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, AU);
    for (int i = 0; i < TMO; i++)
      add(1'b1, 1'b1, 1'b1, A4, 5'b00000, 1'b0, 1'b0, 1'b0, D4, 5'b10000, 5'b10000, 1'b0, AU);
    add(1'b1, 1'b1, 1'b1, A4, 5'b00000, 1'b0, 1'b0, 1'b1, Z, 5'b00000, 5'b00000, 1'b1, A4);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b1, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A4);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, A4);

    // Slave 1 acks exactly in cycle TMO: ack wins over the watchdog.
    add(1'b1, 1'b1, 1'b1, A1, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, A4);
    for (int i = 0; i < TMO - 1; i++)
      add(1'b1, 1'b1, 1'b1, A1, 5'b00000, 1'b0, 1'b0, 1'b0, D1, 5'b00010, 5'b00010, 1'b0, A4);
    add(1'b1, 1'b1, 1'b1, A1, 5'b00010, 1'b0, 1'b1, 1'b0, D1, 5'b00010, 5'b00010, 1'b0, A4);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, A4);

    // Select 5 with err_clr on the entry edge: set wins.
    add(1'b1, 1'b1, 1'b1, A5, 5'b00000, 1'b1, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, A4);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b1, Z, 5'b00000, 5'b00000, 1'b1, A5);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A5);

    // Master abort on slave 1 in cycle 3, slave ack ignored.
    add(1'b1, 1'b1, 1'b1, A1B, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A5);
    for (int i = 0; i < 2; i++)
      add(1'b1, 1'b1, 1'b1, A1B, 5'b00000, 1'b0, 1'b0, 1'b0, D1, 5'b00010, 5'b00010, 1'b1, A5);
    add(1'b1, 1'b0, 1'b0, A1B, 5'b00010, 1'b0, 1'b0, 1'b0, D1, 5'b00000, 5'b00000, 1'b1, A5);
    add(1'b1, 1'b0, 1'b0, Z,   5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A5);

    // Reset in the middle of a slave 3 access.
    add(1'b1, 1'b1, 1'b1, A3, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A5);
    add(1'b1, 1'b1, 1'b1, A3, 5'b00000, 1'b0, 1'b0, 1'b0, D3, 5'b01000, 5'b01000, 1'b1, A5);
    add(1'b0, 1'b1, 1'b1, A3, 5'b01000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b1, A5);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);

    // Stray acks on other slaves during slave 3 access, then a zero-wait beat.
    add(1'b1, 1'b1, 1'b1, A3B, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A3B, 5'b00001, 1'b0, 1'b0, 1'b0, D3, 5'b01000, 5'b01000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A3B, 5'b10111, 1'b0, 1'b0, 1'b0, D3, 5'b01000, 5'b01000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A3B, 5'b01000, 1'b0, 1'b1, 1'b0, D3, 5'b01000, 5'b01000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A3B, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A3B, 5'b01000, 1'b0, 1'b1, 1'b0, D3, 5'b01000, 5'b01000, 1'b0, Z);
    add(1'b1, 1'b0, 1'b0, Z,   5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);

    // Zero-wait read from slave 0 at the top of its window.
    add(1'b1, 1'b1, 1'b1, A0, 5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);
    add(1'b1, 1'b1, 1'b1, A0, 5'b00001, 1'b0, 1'b1, 1'b0, D0, 5'b00001, 5'b00001, 1'b0, Z);
    add(1'b1, 1'b0, 1'b0, Z,  5'b00000, 1'b0, 1'b0, 1'b0, Z, 5'b00000, 5'b00000, 1'b0, Z);

    repeat (2) @(posedge sys_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge sys_clk);
      #1;
      sys_rst = vecs[i].rst;
      m_cyc   = vecs[i].cyc;
      m_stb   = vecs[i].stb;
      m_adr   = vecs[i].adr;
      s_ack   = vecs[i].ack;
      err_clr = vecs[i].clr;
      exp_q.push_back(vecs[i]);
      @(negedge sys_clk);
      e = exp_q.pop_front();
      chk("m_ack",    i, {31'd0, m_ack},    {31'd0, e.e_ack});
      chk("m_err",    i, {31'd0, m_err},    {31'd0, e.e_err});
      chk("m_dat_r",  i, m_dat_r,           e.e_dat);
      chk("s_cyc",    i, {27'd0, s_cyc},    {27'd0, e.e_scyc});
      chk("s_stb",    i, {27'd0, s_stb},    {27'd0, e.e_sstb});
      chk("err_flag", i, {31'd0, err_flag}, {31'd0, e.e_flag});
      chk("err_adr",  i, err_adr,           e.e_eadr);
      chk("ack_err_excl", i, {31'd0, m_ack & m_err}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conbus_slvsel.md
# conbus_slvsel

Slave-side address decoder and bus watchdog for the conbus interconnect. It sits after the arbiter and master multiplexer, receives the single granted Wishbone master cycle, and routes it to one of five slaves selected by address. It returns the slave's ack and read data. It also terminates cycles aimed at unmapped space or at unresponsive slaves with a one-cycle error, and keeps a sticky record of the last faulting address for software.

## Interface
- TIMEOUT, 255: cycles a selected slave may take to ack before the cycle is errored; legal range 1..65535.
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  reset; synchronous and active-low (0 = reset).
- m_adr  input  32  master byte address; bits 31:29 select the slave.
- m_cyc  input  1  master cycle valid.
- m_stb  input  1  master strobe.
- m_ack  output  1  transfer acknowledge to master.
- m_err  output  1  transfer error to master.
- m_dat_r  output  32  read data to master.
- s_cyc  output  5  per-slave cycle, one-hot or zero.
- s_stb  output  5  per-slave strobe, one-hot or zero.
- s_ack  input  5  per-slave acknowledge.
- s_dat_r  input  160  slave read data; slave k on bits 32k+31:32k.
- err_flag  output  1  sticky error indication.
- err_adr  output  32  m_adr of the most recent errored cycle.
- err_clr  input  1  clears err_flag; single-cycle pulse.

## Operation
- States: IDLE, ACTIVE, ERR.
- IDLE, on m_cyc & m_stb:
  - m_adr[31:29] in 0..4: latch sel = m_adr[31:29], clear the watchdog counter, go to ACTIVE.
  - m_adr[31:29] in 5..7: go to ERR.
- ACTIVE:
  - s_cyc[sel] = m_cyc and s_stb[sel] = m_stb; all other bits are 0.
  - m_ack = s_ack[sel] & m_stb; m_dat_r = s_dat_r[sel]. All three are combinational from latched sel.
  - On m_ack, return to IDLE. Each beat is decoded separately.
  - Counter increments every cycle without ack. When counter == TIMEOUT-1 and no ack, go to ERR.
  - If m_cyc drops, return to IDLE silently (abort, no error).
- ERR:
  - m_err = 1 for exactly one cycle; s_cyc and s_stb are 0.
  - err_adr latches m_adr on ERR entry. err_flag is set.
  - Next state is IDLE.
- In IDLE and ERR, m_ack = 0 and m_dat_r = 0.
- Acks on non-selected slaves are ignored.
- err_flag:
  - Set on ERR entry, cleared by err_clr.
  - If set and clear coincide, set wins.
- Counter width is ceil(log2(TIMEOUT+1)). The counter saturates rather than wrapping.

## Timing
- Reset values: state IDLE, sel 0, counter 0, err_flag 0, err_adr 0. All outputs are 0.
- Reset asserted mid-cycle returns to IDLE on the next edge. s_cyc drops in that cycle, with no m_ack or m_err.
- Decode latency is one cycle. Master stb rises in cycle 0, and s_stb[sel] rises in cycle 1.
- A zero-wait slave acks in cycle 1, so m_ack is in cycle 1 and IDLE resumes in cycle 2. Back-to-back beats therefore cost 2 cycles minimum.
- Watchdog: a slave that never acks yields m_err in cycle TIMEOUT+1. s_stb is high during cycles 1..TIMEOUT.
- Ack in the same cycle the counter hits its terminal value: ack wins and no error is raised.
- Unmapped address: stb in cycle 0 gives m_err in cycle 1.
- m_ack and m_err are never asserted together.

## Structure
- Shared conbus package holds:
  - slave count (5)
  - select field position (31:29)
  - state encodings: IDLE=0, ACTIVE=1, ERR=2
- One sub-module is natural: conbus_wdt, holding the load/increment/terminal-count watchdog counter parameterized by TIMEOUT. Decode, muxing and the FSM stay in the top.

## Test plan
- Read from slave 2 (m_adr=0x4000_0010); slave 2 acks after 3 wait cycles with 0xDEADBEEF -> m_ack in cycle 4, m_dat_r=0xDEADBEEF, s_stb=5'b00100 for cycles 1..4, no m_err.
- Access m_adr=0xE000_0000 -> m_err for one cycle in cycle 1, s_cyc stays 0, err_flag=1, err_adr=0xE000_0000.
- TIMEOUT=8, slave 4 never acks -> s_stb[4] high cycles 1..8, m_err in cycle 9, err_adr captured; then err_clr pulse -> err_flag=0 the following cycle.
- Slave acks in exactly cycle TIMEOUT -> m_ack, no m_err, err_flag stays 0.
- Master drops m_cyc in cycle 3 of an ACTIVE access to slave 1 -> s_cyc=0 in that cycle, IDLE next cycle, no m_ack or m_err; also sys_rst=0 mid-access -> all outputs 0 the next cycle.
- Stray s_ack[0] during an access to slave 3 -> no m_ack until s_ack[3].
